boot_copy_seq: RTL and testbench
================================

// Module: boot_copy_seq
// PURPOSE
//  Post-reset sequencer that shadows the synchronous boot ROM into system RAM.
//  Walks ROM addresses 0..COPY_LEN-1 and writes each byte to RAM at DEST_BASE+i through a ready-gated port.
//  Holds the CPU in reset until the copy completes, then releases it.
//  A start pulse re-runs the copy. Sits between bootrom, the RAM write arbiter and the CPU reset.
// PARAMETERS
//  ADDR_W      13        ROM address width; must match the bootrom instance.
//  COPY_LEN    1<<ADDR_W number of bytes copied, 1..2^ADDR_W.
//  RAM_ADDR_W  16        RAM address width.
//  DEST_BASE   16'hE000  RAM address receiving ROM byte 0.
// PORTS
//  clk         in   1           system clock; all state on posedge.
//  rst_n       in   1           asynchronous active-low reset.
//  start       in   1           single-cycle re-copy request; honoured only in DONE.
//  rom_addr    out  ADDR_W      registered address to bootrom.
//  rom_data    in   8           bootrom data, valid one clk after rom_addr is presented.
//  ram_addr    out  RAM_ADDR_W  RAM write address.
//  ram_wdata   out  8           RAM write data.
//  ram_we      out  1           write request; held until accepted.
//  ram_ready   in   1           RAM accepts the write on an edge where ram_we & ram_ready.
//  busy        out  1           copy in progress.
//  done        out  1           copy complete.
//  cpu_rst_n   out  1           CPU reset, low while not DONE.
//  checksum    out  8           mod-256 sum of bytes written in the current run.
// BEHAVIOUR
//  Reset (async, rst_n=0): state=ADDR, idx=0, rom_addr=0, ram_we=0, ram_addr=0, ram_wdata=0,
//   busy=1, done=0, cpu_rst_n=0, checksum=0. The copy starts automatically on release.
//  FSM states: ADDR, WAIT, WRITE, DONE. All outputs are registered.
//   ADDR : rom_addr=idx; the ROM samples it on the edge that ends this state -> WAIT.
//   WAIT : rom_data is valid; capture into ram_wdata; set ram_addr=DEST_BASE+idx
//          (mod 2^RAM_ADDR_W, wraps silently); set ram_we=1 -> WRITE.
//   WRITE: ram_we, ram_addr and ram_wdata are held stable while ram_ready=0 (unbounded wait).
//          On an edge with ram_ready=1:
//            ram_we<=0; checksum<=checksum+ram_wdata.
//            If idx==COPY_LEN-1 -> DONE; else idx<=idx+1 -> ADDR.
//   DONE : busy=0, done=1, cpu_rst_n=1, all set on the edge entering DONE.
//          On start=1: idx=0, checksum=0, busy=1, done=0, cpu_rst_n=0 -> ADDR.
//  Latency: 3 clk per byte when ram_ready=1 throughout, plus 1 clk per ready-low cycle.
//   cpu_rst_n rises 3*COPY_LEN clk after rst_n deasserts.
//  start outside DONE is ignored; no queuing.
//  start coincident with reset is ignored; reset wins.
//  busy and done are never both 1; done==cpu_rst_n always.
//  rst_n asserted mid-copy: immediate return to reset values. The partial RAM image is
//   not scrubbed; the next run overwrites it. ram_we drops asynchronously.
//  idx is ADDR_W bits wide; COPY_LEN=2^ADDR_W terminates on idx==all-ones, with no overflow.
//  rom_data is ignored outside WAIT.
// STRUCTURE
//  Shared package boot_pkg: state encoding localparams (ADDR, WAIT, WRITE, DONE) and the
//   default DEST_BASE / RAM_ADDR_W memory-map constants shared with the address decoder.
//  No sub-modules: a single FSM plus idx counter and checksum accumulator.
//  Instantiated alongside bootrom in the top level; bootrom itself is unchanged.
// TESTING
//  Bench config: ADDR_W=4, COPY_LEN=16, DEST_BASE=16'h0100. ROM model is registered,
//   preloaded with mem[i]=8'h10+i.
//  1 Release rst_n, ram_ready=1 -> 16 writes, 0x0100..0x010F, data 0x10..0x1F, one every 3 clk;
//    cpu_rst_n=1 and done=1 at clk 48; checksum=8'h78.
//  2 ram_ready low 5 clk during the byte 7 write -> ram_we, addr 0x0107, data 0x17 held stable;
//    a single write only; done at clk 53.
//  3 rst_n pulsed low during byte 9 WRITE -> outputs at reset values immediately (ram_we=0,
//    cpu_rst_n=0); the copy restarts from byte 0; 16 full writes follow.
//  4 start pulses at clk 10 and clk 30 (mid-copy) -> ignored; done at clk 48.
//    start pulse in DONE -> busy=1, cpu_rst_n=0 next clk; the copy repeats; checksum=8'h78 again.
//  5 DEST_BASE=16'hFFF8 -> writes wrap: 0xFFF8..0xFFFF then 0x0000..0x0007.
//  6 ram_ready random 50% over 3 full runs -> scoreboard matches 16 writes per run;
//    no duplicate or missing address; busy/done are never both 1.

Source files
------------

// File: rtl/boot_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : boot_pkg                                                      |
// | Purpose  : Shared constants for the boot copy sequencer.                 |
// |            - Boot copy FSM state encoding.                               |
// |            - Default RAM memory-map constants. The system address        |
// |              decoder uses the same values.                               |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
package boot_pkg;

    // Boot copy FSM state encoding
    localparam logic [1:0] c_st_addr  = 2'd0;
    localparam logic [1:0] c_st_wait  = 2'd1;
    localparam logic [1:0] c_st_write = 2'd2;
    localparam logic [1:0] c_st_done  = 2'd3;

    typedef enum logic [1:0] {
        ST_ADDR  = c_st_addr,
        ST_WAIT  = c_st_wait,
        ST_WRITE = c_st_write,
        ST_DONE  = c_st_done
    } boot_state_t;

    // Default memory map: the ROM shadow lands at the top 8 KiB of RAM
    localparam int          c_ram_addr_w = 16;
    localparam logic [15:0] c_dest_base  = 16'hE000;

endpackage
`default_nettype wire

// File: rtl/boot_copy_seq.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : boot_copy_seq                                                 |
// | Purpose  : Post-reset sequencer. It copies the synchronous boot ROM into |
// |            system RAM at DEST_BASE and holds the CPU in reset until the  |
// |            copy completes. A start pulse in DONE runs the copy again.    |
// | Ports    : clk, rst_n      clock / async active-low reset                |
// |            start           re-copy request (used only in DONE)           |
// |            rom_addr/data   registered ROM address, data one clk later    |
// |            ram_addr/wdata  RAM write address / data                      |
// |            ram_we/ready    write request, held until ram_ready           |
// |            busy, done      copy status (never both high)                 |
// |            cpu_rst_n       CPU reset, equals done                        |
// |            checksum        mod-256 sum of bytes written in this run      |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module boot_copy_seq
    import boot_pkg::*;
#(
    parameter int                    ADDR_W     = 13,
    parameter int                    COPY_LEN   = 1 << ADDR_W,
    parameter int                    RAM_ADDR_W = c_ram_addr_w,
    parameter logic [RAM_ADDR_W-1:0] DEST_BASE  = RAM_ADDR_W'(c_dest_base)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    output logic [ADDR_W-1:0]     rom_addr,
    input  logic [7:0]            rom_data,
    output logic [RAM_ADDR_W-1:0] ram_addr,
    output logic [7:0]            ram_wdata,
    output logic                  ram_we,
    input  logic                  ram_ready,
    output logic                  busy,
    output logic                  done,
    output logic                  cpu_rst_n,
    output logic [7:0]            checksum
);

    // Termination compares against the last index. This way COPY_LEN = 2^ADDR_W
    // needs no extra counter bit.
    localparam logic [ADDR_W-1:0] c_idx_last = ADDR_W'(COPY_LEN - 1);

    boot_state_t           r_state, w_state_nxt;
    logic [ADDR_W-1:0]     r_idx, w_idx_nxt;
    logic [ADDR_W-1:0]     r_rom_addr, w_rom_addr_nxt;
    logic [RAM_ADDR_W-1:0] r_ram_addr, w_ram_addr_nxt;
    logic [7:0]            r_ram_wdata, w_ram_wdata_nxt;
    logic                  r_ram_we, w_ram_we_nxt;
    logic                  r_busy, w_busy_nxt;
    logic                  r_done, w_done_nxt;
    logic [7:0]            r_checksum, w_checksum_nxt;
    logic [RAM_ADDR_W-1:0] w_dest;

    // The destination wraps silently at the top of the RAM address space
    assign w_dest = DEST_BASE + RAM_ADDR_W'(r_idx);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_ADDR;
            r_idx       <= '0;
            r_rom_addr  <= '0;
            r_ram_addr  <= '0;
            r_ram_wdata <= '0;
            r_ram_we    <= 1'b0;
            r_busy      <= 1'b1;
            r_done      <= 1'b0;
            r_checksum  <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_idx       <= w_idx_nxt;
            r_rom_addr  <= w_rom_addr_nxt;
            r_ram_addr  <= w_ram_addr_nxt;
            r_ram_wdata <= w_ram_wdata_nxt;
            r_ram_we    <= w_ram_we_nxt;
            r_busy      <= w_busy_nxt;
            r_done      <= w_done_nxt;
            r_checksum  <= w_checksum_nxt;
        end
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_idx_nxt       = r_idx;
        w_rom_addr_nxt  = r_rom_addr;
        w_ram_addr_nxt  = r_ram_addr;
        w_ram_wdata_nxt = r_ram_wdata;
        w_ram_we_nxt    = r_ram_we;
        w_busy_nxt      = r_busy;
        w_done_nxt      = r_done;
        w_checksum_nxt  = r_checksum;

        case (r_state)
            // rom_addr already holds idx. The ROM samples it on this edge.
            ST_ADDR: w_state_nxt = ST_WAIT;

            ST_WAIT: begin
                w_ram_wdata_nxt = rom_data;
                w_ram_addr_nxt  = w_dest;
                w_ram_we_nxt    = 1'b1;
                w_state_nxt     = ST_WRITE;
            end

            ST_WRITE: begin
                if (ram_ready) begin
                    w_ram_we_nxt   = 1'b0;
                    w_checksum_nxt = r_checksum + r_ram_wdata;
                    if (r_idx == c_idx_last) begin
                        w_busy_nxt  = 1'b0;
                        w_done_nxt  = 1'b1;
                        w_state_nxt = ST_DONE;
                    end else begin
                        // Load the next ROM address now so that ADDR takes
                        // only one cycle.
                        w_idx_nxt      = r_idx + ADDR_W'(1);
                        w_rom_addr_nxt = r_idx + ADDR_W'(1);
                        w_state_nxt    = ST_ADDR;
                    end
                end
            end

            ST_DONE: begin
                if (start) begin
                    w_idx_nxt      = '0;
                    w_rom_addr_nxt = '0;
                    w_checksum_nxt = '0;
                    w_busy_nxt     = 1'b1;
                    w_done_nxt     = 1'b0;
                    w_state_nxt    = ST_ADDR;
                end
            end

            default: w_state_nxt = ST_ADDR;
        endcase
    end

    assign rom_addr  = r_rom_addr;
    assign ram_addr  = r_ram_addr;
    assign ram_wdata = r_ram_wdata;
    assign ram_we    = r_ram_we;
    assign busy      = r_busy;
    assign done      = r_done;
    assign cpu_rst_n = r_done;
    assign checksum  = r_checksum;

endmodule
`default_nettype wire

// File: tb/tb_boot_copy_seq.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_boot_copy_seq                                              |
// | Purpose  : Self-checking bench for boot_copy_seq. It uses a 16-byte      |
// |            registered ROM with mem[i] = 8'h10 + i.                       |
// |            Main DUT has DEST_BASE 16'h0100. A second instance has        |
// |            DEST_BASE 16'hFFF8 and exercises the address wrap.            |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module tb_boot_copy_seq;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        ram_ready;
    logic [3:0]  rom_addr, w_rom_addr;
    logic [7:0]  rom_data, w_rom_data;
    logic [15:0] ram_addr, w_ram_addr;
    logic [7:0]  ram_wdata, w_ram_wdata, checksum, w_checksum;
    logic        ram_we, busy, done, cpu_rst_n;
    logic        w_ram_we, w_busy, w_done, w_cpu_rst_n;

    always #5 clk = ~clk;

    boot_copy_seq #(.ADDR_W(4), .COPY_LEN(16), .RAM_ADDR_W(16), .DEST_BASE(16'h0100)) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .rom_addr(rom_addr), .rom_data(rom_data),
        .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_we(ram_we), .ram_ready(ram_ready),
        .busy(busy), .done(done), .cpu_rst_n(cpu_rst_n), .checksum(checksum)
    );

    boot_copy_seq #(.ADDR_W(4), .COPY_LEN(16), .RAM_ADDR_W(16), .DEST_BASE(16'hFFF8)) dut_wrap (
        .clk(clk), .rst_n(rst_n), .start(1'b0),
        .rom_addr(w_rom_addr), .rom_data(w_rom_data),
        .ram_addr(w_ram_addr), .ram_wdata(w_ram_wdata), .ram_we(w_ram_we), .ram_ready(1'b1),
        .busy(w_busy), .done(w_done), .cpu_rst_n(w_cpu_rst_n), .checksum(w_checksum)
    );

    // Registered ROM models
    always @(posedge clk) begin
        rom_data   <= 8'h10 + {4'h0, rom_addr};
        w_rom_data <= 8'h10 + {4'h0, w_rom_addr};
    end

    // Write monitors: the inputs change just after posedge, so at negedge the
    // values seen are the ones the next edge will use.
    logic [15:0] obs_addr [0:1023];
    logic [7:0]  obs_data [0:1023];
    int          n_obs = 0;
    logic [15:0] wobs_addr [0:1023];
    logic [7:0]  wobs_data [0:1023];
    int          n_wobs = 0;
    bit          both_seen = 1'b0;
    bit          neq_seen  = 1'b0;

    always @(negedge clk) begin
        if (rst_n === 1'b1 && ram_we === 1'b1 && ram_ready === 1'b1 && n_obs < 1024) begin
            obs_addr[n_obs] = ram_addr;
            obs_data[n_obs] = ram_wdata;
            n_obs = n_obs + 1;
        end
        if (rst_n === 1'b1 && w_ram_we === 1'b1 && n_wobs < 1024) begin
            wobs_addr[n_wobs] = w_ram_addr;
            wobs_data[n_wobs] = w_ram_wdata;
            n_wobs = n_wobs + 1;
        end
        if (busy === 1'b1 && done === 1'b1) both_seen = 1'b1;
        if (done !== cpu_rst_n)             neq_seen  = 1'b1;
    end

    int          vectors = 0;
    int          miscompares = 0;
    int          rel = 0;
    int          rd = 0;
    logic [23:0] exp_q [$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        rel++;
    endtask

    task automatic push_run();
        for (int i = 0; i < 16; i++)
            exp_q.push_back({16'h0100 + 16'(i), 8'h10 + 8'(i)});
    endtask

    // Compare the observed writes against the scoreboard in order, then discard both
    task automatic drain(input string tag, input int n_exp);
        logic [23:0] e;
        check({tag, "_count"}, 32'(n_obs - rd), 32'(n_exp));
        while (exp_q.size() > 0 && rd < n_obs) begin
            e = exp_q.pop_front();
            check({tag, "_addr"}, {16'h0, obs_addr[rd]}, {16'h0, e[23:8]});
            check({tag, "_data"}, {24'h0, obs_data[rd]}, {24'h0, e[7:0]});
            rd++;
        end
        exp_q.delete();
        rd = n_obs;
    endtask

    task automatic wait_done(input string tag, input int bound);
        int n;
        n = 0;
        while (done !== 1'b1 && n < bound) begin
            tick();
            n++;
        end
        check({tag, "_done_timeout"}, {31'h0, done}, 32'h1);
    endtask

    task automatic reset_and_release();
        rst_n = 1'b0;
        tick();
        rd = n_obs;
        exp_q.delete();
        push_run();
        rst_n = 1'b1;
        rel = 0;
    endtask

    initial begin
        int n;
        rst_n = 1'b0; start = 1'b0; ram_ready = 1'b1;
        tick(); tick();

        // Reset values
        check("rst_busy", {31'h0, busy}, 32'h1);
        check("rst_done", {31'h0, done}, 32'h0);
        check("rst_cpu_rst_n", {31'h0, cpu_rst_n}, 32'h0);
        check("rst_ram_we", {31'h0, ram_we}, 32'h0);
        check("rst_rom_addr", {28'h0, rom_addr}, 32'h0);
        check("rst_ram_addr", {16'h0, ram_addr}, 32'h0);
        check("rst_ram_wdata", {24'h0, ram_wdata}, 32'h0);
        check("rst_checksum", {24'h0, checksum}, 32'h0);

        // 1: plain copy with ram_ready held high
        reset_and_release();
        wait_done("s1", 200);
        check("s1_done_clk", 32'(rel), 32'd48);
        check("s1_cpu_rst_n", {31'h0, cpu_rst_n}, 32'h1);
        check("s1_busy", {31'h0, busy}, 32'h0);
        check("s1_checksum", {24'h0, checksum}, 32'h78);
        drain("s1", 16);

        // 5: the wrap instance ran alongside. Its first 16 writes must wrap.
        check("s5_count", 32'(n_wobs), 32'd16);
        for (int k = 0; k < 16 && k < n_wobs; k++) begin
            check("s5_addr", {16'h0, wobs_addr[k]}, {16'h0, 16'hFFF8 + 16'(k)});
            check("s5_data", {24'h0, wobs_data[k]}, {24'h0, 8'h10 + 8'(k)});
        end
        check("s5_checksum", {24'h0, w_checksum}, 32'h78);

        // 2: ram_ready low for 5 clk while byte 7 is pending
        reset_and_release();
        n = 0;
        while (!(ram_we === 1'b1 && ram_addr === 16'h0107) && n < 100) begin
            tick();
            n++;
        end
        check("s2_reach_b7", {16'h0, ram_addr}, 32'h0107);
        ram_ready = 1'b0;
        repeat (5) begin
            tick();
            check("s2_hold_we", {31'h0, ram_we}, 32'h1);
            check("s2_hold_addr", {16'h0, ram_addr}, 32'h0107);
            check("s2_hold_data", {24'h0, ram_wdata}, 32'h17);
        end
        ram_ready = 1'b1;
        wait_done("s2", 200);
        check("s2_done_clk", 32'(rel), 32'd53);
        drain("s2", 16);

        // 3: async reset while byte 9 is pending, then a full restart
        reset_and_release();
        n = 0;
        while (!(ram_we === 1'b1 && ram_addr === 16'h0109) && n < 100) begin
            tick();
            n++;
        end
        check("s3_reach_b9", {16'h0, ram_addr}, 32'h0109);
        rst_n = 1'b0;
        #1;
        check("s3_async_we", {31'h0, ram_we}, 32'h0);
        check("s3_async_cpu_rst_n", {31'h0, cpu_rst_n}, 32'h0);
        check("s3_async_busy", {31'h0, busy}, 32'h1);
        check("s3_async_rom_addr", {28'h0, rom_addr}, 32'h0);
        check("s3_async_checksum", {24'h0, checksum}, 32'h0);
        drain("s3_partial", 9);
        reset_and_release();
        wait_done("s3", 200);
        check("s3_checksum", {24'h0, checksum}, 32'h78);
        drain("s3", 16);

        // 4: start pulses during the copy are ignored; a start pulse in DONE runs the copy again
        reset_and_release();
        n = 0;
        while (done !== 1'b1 && n < 200) begin
            start = (rel == 9 || rel == 29);
            tick();
            n++;
        end
        start = 1'b0;
        check("s4_done_clk", 32'(rel), 32'd48);
        drain("s4", 16);
        push_run();
        start = 1'b1;
        tick();
        start = 1'b0;
        check("s4_restart_busy", {31'h0, busy}, 32'h1);
        check("s4_restart_done", {31'h0, done}, 32'h0);
        check("s4_restart_cpu_rst_n", {31'h0, cpu_rst_n}, 32'h0);
        check("s4_restart_checksum", {24'h0, checksum}, 32'h0);
        wait_done("s4b", 200);
        check("s4b_checksum", {24'h0, checksum}, 32'h78);
        drain("s4b", 16);

        // 6: ram_ready random over three runs (one after reset, two after start)
        for (int r = 0; r < 3; r++) begin
            if (r == 0) begin
                reset_and_release();
            end else begin
                push_run();
                start = 1'b1;
                tick();
                start = 1'b0;
            end
            n = 0;
            while (done !== 1'b1 && n < 2000) begin
                ram_ready = 1'($urandom_range(0, 1));
                tick();
                n++;
            end
            ram_ready = 1'b1;
            check("s6_done", {31'h0, done}, 32'h1);
            check("s6_checksum", {24'h0, checksum}, 32'h78);
            drain("s6", 16);
        end

        check("busy_and_done", {31'h0, both_seen}, 32'h0);
        check("done_vs_cpu_rst_n", {31'h0, neq_seen}, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
